// File: rtl/div_issue_if.sv
// div_issue_if: start/ready handshake bundle between the divide controller (master) and the divider (slave)
//   dv_start    master->slave  start, held high through the operation
//   dv_dividend master->slave  dividend magnitude
//   dv_divisor  master->slave  divisor magnitude
//   dv_ready    slave->master  result valid
//   dv_result   slave->master  [15:0] quotient, [31:16] remainder (unsigned)
interface div_issue_if;
  logic        dv_start;
  logic [15:0] dv_dividend;
  logic [15:0] dv_divisor;
  logic        dv_ready;
  logic [31:0] dv_result;
  modport master(output dv_start, dv_dividend, dv_divisor, input dv_ready, dv_result);
  modport slave(input dv_start, dv_dividend, dv_divisor, output dv_ready, dv_result);
endinterface

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: EX-stage requester for the iterative 16-bit divider, with sign handling, pipeline stall and HI/LO write
//   clk, rst_n               clock (rising edge), asynchronous active-low reset
//   div_req, div_signed      DIV/DIVU issue from ID/EX (sampled in IDLE only), 1 = signed
//   op_dividend, op_divisor  rs / rt operands
//   flush                    aborts any operation in progress
//   stall, busy              pipeline freeze, controller not idle
//   hilo_we, lo, hi          one-cycle HI/LO write strobe with quotient / remainder
//   div_by_zero              sticky per-operation divide-by-zero flag
//   timeout_err              sticky watchdog flag
//   dv                       divider handshake (div_issue_if.master)
// Optional watchdog: define DIV_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES cycles.
module div_issue_ctrl #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        div_req,
  input  logic        div_signed,
  input  logic [15:0] op_dividend,
  input  logic [15:0] op_divisor,
  input  logic        flush,
  output logic        stall,
  output logic        busy,
  output logic        hilo_we,
  output logic [15:0] lo,
  output logic [15:0] hi,
  output logic        div_by_zero,
  output logic        timeout_err,
  div_issue_if.master dv
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WRITE} state_e;
  state_e      state_q, state_d;
  logic        sa_q, sa_d, sb_q, sb_d, dbz_q, dbz_d;
  logic [15:0] dvd_q, dvd_d, dvs_q, dvs_d;
  logic [15:0] res_lo_q, res_lo_d, res_hi_q, res_hi_d;
  logic [15:0] lo_q, lo_d, hi_q, hi_d;
  logic        sa_in, sb_in, expire;
  logic [15:0] q_u, r_u;
  assign sa_in = op_dividend[15] & div_signed;
  assign sb_in = op_divisor[15] & div_signed;
  assign q_u   = dv.dv_result[15:0];
  assign r_u   = dv.dv_result[31:16];
`ifdef DIV_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;
  // counter is zero on the first WAIT cycle, so expiry lands on the TIMEOUT_CYCLES-th WAIT cycle
  assign expire      = state_q == WAIT && !dv.dv_ready && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  assign cnt_d       = state_q == WAIT ? cnt_q + 1'b1 : '0;
  assign tmo_d       = tmo_q | (expire & ~flush);
  assign timeout_err = tmo_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
`else
  logic unused_tmo;
  assign expire      = 1'b0;
  assign unused_tmo  = |TIMEOUT_CYCLES;
  assign timeout_err = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      dbz_q    <= 1'b0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      dbz_q    <= dbz_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
    end
  // result registers hold the pending HI/LO value; divide-by-zero preloads them and skips the divider
  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    dbz_d    = dbz_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    if (flush) state_d = IDLE;
    else case (state_q)
      IDLE: if (div_req) begin
        state_d  = op_divisor == '0 ? WRITE : ISSUE;
        sa_d     = sa_in;
        sb_d     = sb_in;
        dbz_d    = op_divisor == '0;
        dvd_d    = sa_in ? -op_dividend : op_dividend;
        dvs_d    = sb_in ? -op_divisor : op_divisor;
        res_lo_d = 16'hFFFF;
        res_hi_d = op_dividend;
      end
      ISSUE: state_d = WAIT;
      WAIT: if (dv.dv_ready) begin
        state_d  = WRITE;
        res_lo_d = (sa_q ^ sb_q) ? -q_u : q_u;
        res_hi_d = sa_q ? -r_u : r_u;
      end else if (expire) state_d = IDLE;
      WRITE: begin
        state_d = IDLE;
        lo_d    = res_lo_q;
        hi_d    = res_hi_q;
      end
    endcase
  end
  // hi/lo show the new value during the write strobe; a flush in WRITE suppresses both
  always_comb begin
    busy           = state_q != IDLE;
    stall          = (state_q == IDLE && div_req && !flush) || state_q == ISSUE || state_q == WAIT;
    hilo_we        = state_q == WRITE && !flush;
    lo             = hilo_we ? res_lo_q : lo_q;
    hi             = hilo_we ? res_hi_q : hi_q;
    div_by_zero    = dbz_q;
    dv.dv_start    = state_q == ISSUE || state_q == WAIT;
    dv.dv_dividend = dvd_q;
    dv.dv_divisor  = dvs_q;
  end
endmodule
